// File: rtl/rf_writeback_arbiter.sv
// Writeback arbiter: merges eu0/eu1 results with buffered long-latency results onto two RF write ports.
// Optional performance counters are enabled by defining WB_PERF_CNT_EN.
module rf_writeback_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              eu0_valid,
  input  logic [4:0]        eu0_rd,
  input  logic [5:0]        eu0_exp,
  input  logic [31:0]       eu0_data,
  input  logic              eu1_valid,
  input  logic [4:0]        eu1_rd,
  input  logic [5:0]        eu1_exp,
  input  logic [31:0]       eu1_data,
  input  logic              ll_valid,
  output logic              ll_ready,
  input  logic [4:0]        ll_rd,
  input  logic [31:0]       ll_data,
  output logic              write_en_0,
  output logic [ADDR_W-1:0] write_addr_0,
  output logic [31:0]       write_data_0,
  output logic              write_en_1,
  output logic [ADDR_W-1:0] write_addr_1,
  output logic [31:0]       write_data_1
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_wr_cnt,
  output logic [31:0]       perf_ll_stall_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [4:0]       fifo_rd_r   [FIFO_DEPTH];
  logic [31:0]      fifo_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] head1_ptr_s;
  logic [CNT_W-1:0] count_r;

  logic             eu0_live_s;
  logic             eu1_live_s;
  logic             push_s;
  logic [1:0]       pop_cnt_s;

  logic             p0_en_s;
  logic [4:0]       p0_rd_s;
  logic [31:0]      p0_data_s;
  logic             p1_en_s;
  logic [4:0]       p1_rd_s;
  logic [31:0]      p1_data_s;
  logic             p1_older_s;
  logic             collide_s;
  logic             wr0_en_s;
  logic             wr1_en_s;

  function automatic logic eu_live(input logic valid, input logic [4:0] rd,
                                   input logic [5:0] exp_code, input logic fl);
    return valid && (rd != 5'd0) && (exp_code == 6'd0) && !fl;
  endfunction

  assign eu0_live_s  = eu_live(eu0_valid, eu0_rd, eu0_exp, flush);
  assign eu1_live_s  = eu_live(eu1_valid, eu1_rd, eu1_exp, flush);
  assign ll_ready    = (count_r != FULL_CNT);
  assign push_s      = ll_valid && ll_ready && !flush;
  assign head1_ptr_s = rd_ptr_r + PTR_W'(1);

  // Port source selection: eu results own their port, free ports drain the FIFO oldest-first.
  always_comb begin
    p0_en_s    = 1'b0;
    p0_rd_s    = 5'd0;
    p0_data_s  = 32'd0;
    p1_en_s    = 1'b0;
    p1_rd_s    = 5'd0;
    p1_data_s  = 32'd0;
    p1_older_s = 1'b0;
    pop_cnt_s  = 2'd0;

    if (eu0_live_s) begin
      p0_en_s   = 1'b1;
      p0_rd_s   = eu0_rd;
      p0_data_s = eu0_data;
    end else if (!flush && (count_r != CNT_W'(0))) begin
      p0_en_s   = (fifo_rd_r[rd_ptr_r] != 5'd0);
      p0_rd_s   = fifo_rd_r[rd_ptr_r];
      p0_data_s = fifo_data_r[rd_ptr_r];
      pop_cnt_s = 2'd1;
    end else begin
      p0_en_s   = 1'b0;
    end

    if (eu1_live_s) begin
      p1_en_s   = 1'b1;
      p1_rd_s   = eu1_rd;
      p1_data_s = eu1_data;
    end else if (flush) begin
      p1_en_s   = 1'b0;
    end else if (!eu0_live_s && (count_r >= CNT_W'(2))) begin
      p1_en_s   = (fifo_rd_r[head1_ptr_s] != 5'd0);
      p1_rd_s   = fifo_rd_r[head1_ptr_s];
      p1_data_s = fifo_data_r[head1_ptr_s];
      pop_cnt_s = 2'd2;
    end else if (eu0_live_s && (count_r != CNT_W'(0))) begin
      // FIFO head lands on port 1 while eu0 holds port 0, so port 1 carries the older value.
      p1_en_s    = (fifo_rd_r[rd_ptr_r] != 5'd0);
      p1_rd_s    = fifo_rd_r[rd_ptr_r];
      p1_data_s  = fifo_data_r[rd_ptr_r];
      p1_older_s = 1'b1;
      pop_cnt_s  = 2'd1;
    end else begin
      p1_en_s   = 1'b0;
    end
  end

  assign collide_s = p0_en_s && p1_en_s && (p0_rd_s == p1_rd_s);
  assign wr0_en_s  = p0_en_s && !(collide_s && !p1_older_s);
  assign wr1_en_s  = p1_en_s && !(collide_s && p1_older_s);

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r <= rd_ptr_r + PTR_W'(pop_cnt_s);
      count_r  <= count_r + CNT_W'(push_s) - CNT_W'(pop_cnt_s);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_rd_r[i]   <= 5'd0;
        fifo_data_r[i] <= 32'd0;
      end
    end else if (push_s) begin
      fifo_rd_r[wr_ptr_r]   <= ll_rd;
      fifo_data_r[wr_ptr_r] <= ll_data;
    end else begin
      fifo_rd_r[wr_ptr_r]   <= fifo_rd_r[wr_ptr_r];
      fifo_data_r[wr_ptr_r] <= fifo_data_r[wr_ptr_r];
    end
  end

  // Registered RF write ports; address/data hold their last value while disabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      write_en_0   <= 1'b0;
      write_addr_0 <= '0;
      write_data_0 <= 32'd0;
      write_en_1   <= 1'b0;
      write_addr_1 <= '0;
      write_data_1 <= 32'd0;
    end else begin
      write_en_0 <= wr0_en_s;
      write_en_1 <= wr1_en_s;
      if (wr0_en_s) begin
        write_addr_0 <= ADDR_W'(p0_rd_s);
        write_data_0 <= p0_data_s;
      end else begin
        write_addr_0 <= write_addr_0;
        write_data_0 <= write_data_0;
      end
      if (wr1_en_s) begin
        write_addr_1 <= ADDR_W'(p1_rd_s);
        write_data_1 <= p1_data_s;
      end else begin
        write_addr_1 <= write_addr_1;
        write_data_1 <= write_data_1;
      end
    end
  end

`ifdef WB_PERF_CNT_EN
  // Performance counters survive flush and wrap naturally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_wr_cnt       <= 32'd0;
      perf_ll_stall_cnt <= 32'd0;
    end else begin
      perf_wr_cnt <= perf_wr_cnt + 32'(write_en_0) + 32'(write_en_1);
      if (ll_valid && !ll_ready) begin
        perf_ll_stall_cnt <= perf_ll_stall_cnt + 32'd1;
      end else begin
        perf_ll_stall_cnt <= perf_ll_stall_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Scoreboard bench for rf_writeback_arbiter: expected writes are queued per port with the
// cycle they must appear in, and a negedge monitor pops and compares them.
module tb_rf_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        eu0_valid, eu1_valid, ll_valid, ll_ready;
  logic [4:0]  eu0_rd, eu1_rd, ll_rd;
  logic [5:0]  eu0_exp, eu1_exp;
  logic [31:0] eu0_data, eu1_data, ll_data;
  logic        write_en_0, write_en_1;
  logic [31:0] write_addr_0, write_addr_1, write_data_0, write_data_1;
`ifdef WB_PERF_CNT_EN
  logic [31:0] perf_wr_cnt, perf_ll_stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t q0[$];
  wr_t q1[$];

  rf_writeback_arbiter #(.FIFO_DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .eu0_valid(eu0_valid), .eu0_rd(eu0_rd), .eu0_exp(eu0_exp), .eu0_data(eu0_data),
    .eu1_valid(eu1_valid), .eu1_rd(eu1_rd), .eu1_exp(eu1_exp), .eu1_data(eu1_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .write_en_0(write_en_0), .write_addr_0(write_addr_0), .write_data_0(write_data_0),
    .write_en_1(write_en_1), .write_addr_1(write_addr_1), .write_data_1(write_data_1)
`ifdef WB_PERF_CNT_EN
    , .perf_wr_cnt(perf_wr_cnt), .perf_ll_stall_cnt(perf_ll_stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every enabled port must match the entry expected for this cycle.
  always @(negedge clk) begin : mon
    logic        m_en;
    logic [31:0] m_a, m_d;
    wr_t         m_e;
    bit          m_have;
    if (rstn === 1'b1) begin
      for (int p = 0; p < 2; p++) begin
        m_en   = (p == 0) ? write_en_0 : write_en_1;
        m_a    = (p == 0) ? write_addr_0 : write_addr_1;
        m_d    = (p == 0) ? write_data_0 : write_data_1;
        m_have = 1'b0;
        m_e    = '{cyc: 0, addr: 32'd0, data: 32'd0};
        if (p == 0) begin
          if (q0.size() > 0 && q0[0].cyc == cyc) begin m_e = q0.pop_front(); m_have = 1'b1; end
        end else begin
          if (q1.size() > 0 && q1[0].cyc == cyc) begin m_e = q1.pop_front(); m_have = 1'b1; end
        end
        if (m_en === 1'b1 || m_have) begin
          n_checks++;
          if (m_en !== m_have) begin
            n_fail++;
            $display("FAIL wr_port%0d_en cyc=%0d: write_en=%0b addr=%0d, expected en=%0b addr=%0d",
                     p, cyc, m_en, m_a, m_have, m_e.addr);
          end else if (m_a !== m_e.addr || m_d !== m_e.data) begin
            n_fail++;
            $display("FAIL wr_port%0d_val cyc=%0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                     p, cyc, m_a, m_d, m_e.addr, m_e.data);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0;
    eu0_valid = 1'b0; eu0_rd = 5'd0; eu0_exp = 6'd0; eu0_data = 32'd0;
    eu1_valid = 1'b0; eu1_rd = 5'd0; eu1_exp = 6'd0; eu1_data = 32'd0;
    ll_valid  = 1'b0; ll_rd  = 5'd0; ll_data = 32'd0;
  endtask

  task automatic set_eu0(input logic [4:0] rd, input logic [5:0] ex, input logic [31:0] d);
    eu0_valid = 1'b1; eu0_rd = rd; eu0_exp = ex; eu0_data = d;
  endtask

  task automatic set_eu1(input logic [4:0] rd, input logic [5:0] ex, input logic [31:0] d);
    eu1_valid = 1'b1; eu1_rd = rd; eu1_exp = ex; eu1_data = d;
  endtask

  task automatic set_ll(input logic [4:0] rd, input logic [31:0] d);
    ll_valid = 1'b1; ll_rd = rd; ll_data = d;
  endtask

  task automatic exp_wr(input int p, input int c, input logic [4:0] rd, input logic [31:0] d);
    wr_t e;
    e.cyc  = c;
    e.addr = {27'd0, rd};
    e.data = d;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    #7;
    n_checks++; if (write_en_0 !== 1'b0)     begin n_fail++; $display("FAIL rst_en0: got %b, expected 0", write_en_0); end
    n_checks++; if (write_en_1 !== 1'b0)     begin n_fail++; $display("FAIL rst_en1: got %b, expected 0", write_en_1); end
    n_checks++; if (write_addr_0 !== 32'd0)  begin n_fail++; $display("FAIL rst_addr0: got %h, expected 0", write_addr_0); end
    n_checks++; if (write_addr_1 !== 32'd0)  begin n_fail++; $display("FAIL rst_addr1: got %h, expected 0", write_addr_1); end
    n_checks++; if (write_data_0 !== 32'd0)  begin n_fail++; $display("FAIL rst_data0: got %h, expected 0", write_data_0); end
    n_checks++; if (write_data_1 !== 32'd0)  begin n_fail++; $display("FAIL rst_data1: got %h, expected 0", write_data_1); end
    n_checks++; if (ll_ready !== 1'b1)       begin n_fail++; $display("FAIL rst_ll_ready: got %b, expected 1", ll_ready); end
    step();
    rstn = 1'b1;
    step();
  endtask

  task automatic test_dual_eu();
    logic [31:0] d0, d1;
    set_eu0(5'd5, 6'd0, 32'h11); set_eu1(5'd6, 6'd0, 32'h22);
    exp_wr(0, cyc + 1, 5'd5, 32'h11); exp_wr(1, cyc + 1, 5'd6, 32'h22);
    step();
    for (int i = 0; i < 4; i++) begin
      d0 = $urandom; d1 = $urandom;
      set_eu0(5'(31 - i), 6'd0, d0); set_eu1(5'(1 + i), 6'd0, d1);
      exp_wr(0, cyc + 1, 5'(31 - i), d0); exp_wr(1, cyc + 1, 5'(1 + i), d1);
      step();
    end
    idle(); step(); step();
  endtask

  task automatic test_collision();
    set_eu0(5'd7, 6'd0, 32'd1); set_eu1(5'd7, 6'd0, 32'd2);
    exp_wr(1, cyc + 1, 5'd7, 32'd2);
    step();
    idle(); step(); step();
  endtask

  task automatic test_suppress();
    set_eu0(5'd0, 6'd0, 32'hDEAD); set_eu1(5'd3, 6'h0C, 32'hBEEF); set_ll(5'd12, 32'hABC);
    exp_wr(0, cyc + 2, 5'd12, 32'hABC);
    step();
    idle(); step(); step();
    set_ll(5'd0, 32'h5A5A);
    step();
    set_ll(5'd17, 32'h177);
    exp_wr(0, cyc + 2, 5'd17, 32'h177);
    step();
    idle(); step(); step();
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 5; i++) begin
      set_eu0(5'd10, 6'd0, 32'hA00 + 32'(i)); set_eu1(5'd11, 6'd0, 32'hB00 + 32'(i));
      exp_wr(0, cyc + 1, 5'd10, 32'hA00 + 32'(i)); exp_wr(1, cyc + 1, 5'd11, 32'hB00 + 32'(i));
      set_ll(5'(i + 1), 32'h100 + 32'(i + 1));
      n_checks++;
      if (ll_ready !== (i < 4)) begin
        n_fail++; $display("FAIL fill_ready%0d: ll_ready=%b, expected %0b", i, ll_ready, (i < 4));
      end
      step();
    end
    eu0_valid = 1'b0; eu1_valid = 1'b0;
    n_checks++;
    if (ll_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold: ll_ready=%b, expected 0", ll_ready); end
    exp_wr(0, cyc + 1, 5'd1, 32'h101); exp_wr(1, cyc + 1, 5'd2, 32'h102);
    step();
    n_checks++;
    if (ll_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready: ll_ready=%b, expected 1", ll_ready); end
    exp_wr(0, cyc + 1, 5'd3, 32'h103); exp_wr(1, cyc + 1, 5'd4, 32'h104);
    exp_wr(0, cyc + 2, 5'd5, 32'h105);
    step();
    idle(); step(); step(); step();
  endtask

  task automatic test_head_collision();
    set_eu0(5'd20, 6'd0, 32'h200); set_eu1(5'd21, 6'd0, 32'h210); set_ll(5'd9, 32'h99);
    exp_wr(0, cyc + 1, 5'd20, 32'h200); exp_wr(1, cyc + 1, 5'd21, 32'h210);
    step();
    idle(); set_eu0(5'd9, 6'd0, 32'h55);
    exp_wr(0, cyc + 1, 5'd9, 32'h55);
    step();
    idle();
    set_eu0(5'd22, 6'd0, 32'h220); set_eu1(5'd23, 6'd0, 32'h230); set_ll(5'd13, 32'h13);
    exp_wr(0, cyc + 1, 5'd22, 32'h220); exp_wr(1, cyc + 1, 5'd23, 32'h230);
    step();
    idle(); set_eu0(5'd14, 6'd0, 32'h14);
    exp_wr(0, cyc + 1, 5'd14, 32'h14); exp_wr(1, cyc + 1, 5'd13, 32'h13);
    step();
    idle(); step(); step();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      set_eu0(5'd10, 6'd0, 32'hC00 + 32'(i)); set_eu1(5'd11, 6'd0, 32'hC10 + 32'(i));
      exp_wr(0, cyc + 1, 5'd10, 32'hC00 + 32'(i)); exp_wr(1, cyc + 1, 5'd11, 32'hC10 + 32'(i));
      set_ll(5'(21 + i), 32'h2100 + 32'(i));
      step();
    end
    flush = 1'b1;
    set_eu0(5'd4, 6'd0, 32'h44); set_eu1(5'd5, 6'd0, 32'h55); set_ll(5'd24, 32'h24);
    step();
    idle();
    n_checks++;
    if (ll_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: ll_ready=%b, expected 1", ll_ready); end
    set_ll(5'd25, 32'h25);
    exp_wr(0, cyc + 2, 5'd25, 32'h25);
    step();
    idle(); step(); step(); step();
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) begin
      set_eu0(5'd10, 6'd0, 32'hD00 + 32'(i)); set_eu1(5'd11, 6'd0, 32'hD10 + 32'(i));
      exp_wr(0, cyc + 1, 5'd10, 32'hD00 + 32'(i)); exp_wr(1, cyc + 1, 5'd11, 32'hD10 + 32'(i));
      set_ll(5'(1 + i), 32'h300 + 32'(i));
      step();
    end
    idle();
    exp_wr(0, cyc + 1, 5'd1, 32'h300); exp_wr(1, cyc + 1, 5'd2, 32'h301);
    step();
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    n_checks++; if (write_en_0 !== 1'b0)    begin n_fail++; $display("FAIL arst_en0: got %b, expected 0", write_en_0); end
    n_checks++; if (write_en_1 !== 1'b0)    begin n_fail++; $display("FAIL arst_en1: got %b, expected 0", write_en_1); end
    n_checks++; if (write_addr_0 !== 32'd0) begin n_fail++; $display("FAIL arst_addr0: got %h, expected 0", write_addr_0); end
    n_checks++; if (write_data_1 !== 32'd0) begin n_fail++; $display("FAIL arst_data1: got %h, expected 0", write_data_1); end
    n_checks++; if (ll_ready !== 1'b1)      begin n_fail++; $display("FAIL arst_ready: got %b, expected 1", ll_ready); end
    step(); step();
    rstn = 1'b1;
    step();
    set_ll(5'd26, 32'h26);
    exp_wr(0, cyc + 2, 5'd26, 32'h26);
    step();
    idle(); step(); step(); step();
  endtask

  initial begin
    test_reset();
    test_dual_eu();
    test_collision();
    test_suppress();
    test_fifo_full();
    test_head_collision();
    test_flush();
    test_reset_mid_drain();
    step(); step();
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expect: %0d/%0d writes never seen, expected 0/0", q0.size(), q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Writeback stage behind exe2; owns both register-file write ports (write_en_0/1, write_addr_0/1, write_data_0/1) consumed by the RF read/bypass stage.
- Merges single-cycle results from eu0/eu1 with long-latency results (mul/div/load) buffered in a small FIFO.
- Suppresses r0 and excepting writes and resolves same-rd collisions by age, so the RF always holds the youngest value.

Parameters:
- FIFO_DEPTH, 4, long-latency result buffer entries (power of 2, >=2)
- ADDR_W, 32, width of write_addr_0/1 (rd zero-extended)

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- flush  in  1  pipeline flush; drops same-cycle eu0/eu1 results and empties FIFO
- eu0_valid  in  1  eu0 result valid this cycle
- eu0_rd  in  5  eu0 destination
- eu0_exp  in  6  eu0 exception code, nonzero = faulted
- eu0_data  in  32  eu0 result
- eu1_valid/eu1_rd/eu1_exp/eu1_data  in  1/5/6/32  same for eu1
- ll_valid  in  1  long-latency result offered
- ll_ready  out  1  FIFO not full
- ll_rd  in  5  long-latency destination
- ll_data  in  32  long-latency result
- write_en_0  out  1  RF port 0 enable
- write_addr_0  out  ADDR_W  RF port 0 address
- write_data_0  out  32  RF port 0 data
- write_en_1/write_addr_1/write_data_1  out  1/ADDR_W/32  RF port 1

Behaviour:
- Reset (rstn=0, async): write_en_0/1=0, write_addr_0/1=0, write_data_0/1=0, FIFO empty, ll_ready=1.
- Candidate eu write is live iff valid && rd!=0 && exp==0 && !flush.
- Outputs are registered: candidate in cycle N appears on the write ports in cycle N+1.
- Long-latency results always pass through the FIFO; min latency ll accept to RF write is 2 cycles.
- ll push on ll_valid && ll_ready; ll_ready = !full (registered count).
- ll_rd==0 entries are pushed, then popped silently without a write.
- Port assignment: live eu0 -> port 0; live eu1 -> port 1.
- Free ports are filled from the FIFO head, oldest first: port 0 first, then port 1.
- Up to 2 pops per cycle when both eu results are absent.
- Age order within a cycle: FIFO head < FIFO head+1 < eu0 < eu1.
- If two selected writes share rd, only the younger is enabled; the older is still consumed (popped/dropped).
- Push and pop in the same cycle are allowed when full: a pop frees space, but ll_ready reflects the start-of-cycle count, so no push occurs while full.
- Pointer wrap-around is modulo FIFO_DEPTH; count is FIFO_DEPTH+1 states.
- flush: FIFO pointers and count cleared next edge, same-cycle ll push ignored, write ports deasserted next cycle.
- A write registered before the flush cycle still completes.
- No output is combinationally dependent on the inputs except ll_ready (from state only).

Optional Feature:
- Macro WB_PERF_CNT_EN.
- Defined: adds outputs perf_wr_cnt (32) and perf_ll_stall_cnt (32), both reset to 0 by rstn.
- perf_wr_cnt increments by the number of enabled write ports each cycle (0/1/2).
- perf_ll_stall_cnt increments on ll_valid && !ll_ready.
- Both wrap at 2^32 and are not cleared by flush.
- Undefined: ports and counters absent; core behaviour unchanged.

Test Plan:
- eu0 {rd=5, data=0x11}, eu1 {rd=6, data=0x22} -> next cycle write_en_0=1 addr 5 data 0x11; write_en_1=1 addr 6 data 0x22.
- eu0 {rd=7, data=1}, eu1 {rd=7, data=2} same cycle -> write_en_0=0, write_en_1=1 addr 7 data 2.
- eu0 rd=0 and eu1 exp=0x0C -> both write enables 0; an ll entry queued behind them drains on port 0.
- Push 4 ll results {rd 1..4} with eu0/eu1 busy on rd 10/11 -> ll_ready=0 after the 4th; 5th ll_valid held. Release eu -> 1,2 written, then 3,4, then the 5th accepted.
- FIFO head rd=9 while eu0 rd=9 and eu1 idle -> only eu0 value written to r9; head popped.
- 3 entries queued, flush -> FIFO empty, no ll writes follow, ll_ready=1; rstn pulsed mid-drain -> all outputs 0 immediately.
